mul_add_issue: RTL and testbench

MUL_ADD_ISSUE -- requirements
Module: mul_add_issue

---
 rtl/mul_add_issue.sv | 129 ++++++++++++
 tb/tb_mul_add_issue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_issue.sv
// mul_add_issue
// Credit-based issue stage for an external fixed-latency multiply-add
// pipeline, with an in-order result FIFO on the far side.
//
// Operands pass straight through to the pipeline (pipe_x/y/z). A valid
// shift register (vld) tracks which cycles carry real work. Each result is
// written into a DEPTH-entry FIFO. An issue is only allowed while a credit
// is free, so the FIFO can never be asked to take a result it has no room
// for.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready producer handshake for operand triple in_x/in_y/in_z
//   pipe_x/y/z        operands to the downstream pipeline (combinational)
//   pipe_result       pipeline output, valid when vld[LATENCY-1] is set
//   out_valid/ready   consumer handshake, out_data = FIFO head
//   credits           free issue credits (DEPTH at reset)
//   overflow_err      sticky: a FIFO write was attempted while full
module mul_add_issue #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_x,
  input  logic [WIDTH-1:0]         in_y,
  input  logic [WIDTH-1:0]         in_z,
  output logic [WIDTH-1:0]         pipe_x,
  output logic [WIDTH-1:0]         pipe_y,
  output logic [WIDTH-1:0]         pipe_z,
  input  logic [WIDTH-1:0]         pipe_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [LATENCY-1:0] vld;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic issue, push, pop, full, wr_en;

  // The pipeline has no valid input; it just computes on whatever it sees.
  assign pipe_x = in_x;
  assign pipe_y = in_y;
  assign pipe_z = in_z;

  // Ready depends only on registered credits; rst_n gating keeps it low
  // for the whole reset window even though credits resets to DEPTH.
  assign in_ready  = rst_n && (credits != '0);
  assign issue     = in_valid && in_ready;

  assign push      = vld[LATENCY-1];
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid && out_ready;
  // A write into a full FIFO is dropped (and flagged), even if a pop
  // happens on the same edge: that situation means credit accounting broke.
  assign wr_en     = push && !full;

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Valid tracker, one bit per pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
    end
  end

  // Result FIFO storage. Cleared on reset so out_data reads 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= pipe_result;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A credit is held from issue until the matching result leaves the FIFO,
  // so credits == DEPTH - (in flight + stored).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= DEPTH_C;
    end else if (issue && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !issue) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (push && full) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_add_issue.sv
module tb_mul_add_issue;

  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, overflow_err;
  logic [W-1:0]  in_x, in_y, in_z, pipe_x, pipe_y, pipe_z, pipe_result, out_data;
  logic [2:0]    credits;

  always #5 clk = ~clk;

  mul_add_issue #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_z(pipe_z), .pipe_result(pipe_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .credits(credits), .overflow_err(overflow_err)
  );

  // Downstream pipeline: LAT register stages, always computing.
  logic [W-1:0] pst [LAT];
  always @(posedge clk) begin
    pst[0] <= pipe_x * pipe_y + pipe_z;
    for (int i = 1; i < LAT; i++) pst[i] <= pst[i-1];
  end
  assign pipe_result = pst[LAT-1];

  int n_chk = 0;
  int n_err = 0;
  int n_iss = 0;
  int n_pop = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: sampled after the negedge drive, i.e. the values that the
  // next rising edge will act on.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_pop: got result %0h with nothing outstanding", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              n_err++;
              $display("FAIL sb_order: got %0h expected %0h", out_data, e);
            end
          end
          n_pop++;
        end
        if (in_valid && in_ready) begin
          e = in_x * in_y + in_z;
          exp_q.push_back(e);
          n_iss++;
        end
      end
    end
  end

  typedef struct {
    logic [W-1:0] x, y, z, res;
  } vec_t;
  vec_t tbl [7];

  task automatic single_op(input vec_t v, input string nm);
    @(negedge clk);
    check({nm, "_rdy"}, in_ready, 1);
    in_valid = 1'b1; in_x = v.x; in_y = v.y; in_z = v.z;
    #1 check({nm, "_pipe"}, {pipe_x, pipe_y, pipe_z}, {v.x, v.y, v.z});
    @(negedge clk);                     // first cycle after accept edge
    in_valid = 1'b0;
    check({nm, "_cred_dec"}, credits, 3);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      check({nm, "_early"}, out_valid, 0);
    end
    @(negedge clk);                     // fourth cycle: result visible
    check({nm, "_vld"}, out_valid, 1);
    check({nm, "_data"}, out_data, v.res);
    @(negedge clk);
    check({nm, "_cred_back"}, credits, 4);
    check({nm, "_empty"}, out_valid, 0);
  endtask

  initial begin
    int ib, pb;
    tbl[0] = '{32'd3,         32'd5,         32'd7,         32'd22};
    tbl[1] = '{32'hFFFF_FFFF, 32'd2,         32'd3,         32'h0000_0001};
    tbl[2] = '{32'd0,         32'd0,         32'd0,         32'd0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
    tbl[4] = '{32'h0001_0000, 32'h0001_0000, 32'd5,         32'd5};
    tbl[5] = '{32'h0000_1234, 32'h10,        32'hFFFF_FFFF, 32'h0001_233F};
    tbl[6] = '{32'd7,         32'd6,         32'hFFFF_FFF0, 32'h1A};

    in_valid = 0; out_ready = 1; in_x = 0; in_y = 0; in_z = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_credits", credits, 4);
    check("rst_overflow", overflow_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // Single operations from the vector table.
    for (int i = 0; i < 7; i++) single_op(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: consumer stalled, producer always offering.
    ib = n_iss;
    out_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1; in_x = $urandom; in_y = $urandom; in_z = $urandom;
    end
    @(negedge clk);
    check("bp_issues", n_iss - ib, 4);
    check("bp_ready_low", in_ready, 0);
    check("bp_credits0", credits, 0);
    check("bp_full_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume", in_ready, 1);

    // Streaming with random operands; credit invariant each cycle.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("st_credit_inv", credits, 3'(DEP - exp_q.size()));
      in_x = $urandom; in_y = $urandom; in_z = $urandom;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("st_drained", exp_q.size(), 0);
    check("st_credits", credits, 4);
    check("st_out_valid", out_valid, 0);
    check("st_overflow", overflow_err, 0);

    // Pointer wrap: 12 results through a 4-entry FIFO, out_ready toggling.
    ib = n_iss; pb = n_pop;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      out_ready = c[0] ? 1'b0 : 1'b1;
      in_valid  = (n_iss - ib) < 12;
      in_x = c + 1; in_y = c * 3 + 2; in_z = 32'hFFFF_0000 + c;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("wrap_issues", n_iss - ib, 12);
    check("wrap_pops", n_pop - pb, 12);
    check("wrap_credits", credits, 4);
    check("wrap_overflow", overflow_err, 0);

    // Reset with two results in flight.
    @(negedge clk);
    in_valid = 1'b1; in_x = 11; in_y = 12; in_z = 13;
    @(negedge clk);
    in_x = 21; in_y = 22; in_z = 23;
    @(negedge clk);
    in_valid = 1'b0;
    check("mf_inflight_cred", credits, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mf_rst_ready", in_ready, 0);
    check("mf_rst_cred", credits, 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("mf_no_stale", out_valid, 0);
    end
    check("mf_cred", credits, 4);
    check("mf_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
